// File: rtl/node_sequencer.sv
// node_sequencer: per-iteration command sequencer for a node replica chain.
// Turns one start request into the ordered strobe sequence of each annealing
// iteration (draw, distance, accept, ordering, optional exchange) and repeats
// it for the latched iteration count.
module node_sequencer #(
  parameter int unsigned DIST_CYCLES = 8,
  parameter int unsigned ORD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] iterations,
  input  logic [7:0]  exchange_interval,
  output logic        busy,
  output logic        done,
  output logic [23:0] iter_idx,
  output logic        random_init,
  output logic        random_run,
  output logic        distance_start,
  output logic        metropolis_run,
  output logic        exchange_valid,
  output logic        rbank,
  output logic        replica_run,
  output logic        exchange_run,
  output logic        shift_distance,
  output logic        opt_sel
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] DistLoad = CntW'(DIST_CYCLES - 1);
  localparam logic [CntW-1:0] OrdLoad  = CntW'(ORD_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StSeed, StRand, StDist, StMetro, StOrd, StRepl, StXchg, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      phase_q, phase_d;
  logic [23:0]     iter_idx_q, iter_idx_d;
  logic [23:0]     iters_q, iters_d;
  logic [7:0]      intv_q, intv_d;
  logic            rbank_q, rbank_d;
  logic [23:0]     iter_inc;
  logic            take_next;

  // Strobe vector: busy, done, random_init, random_run, distance_start,
  // metropolis_run, exchange_valid, replica_run, exchange_run, shift_distance.
  logic [9:0]      strobes_q, strobes_d;

  assign iter_inc = iter_idx_q + 24'd1;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      phase_q    <= '0;
      iter_idx_q <= '0;
      iters_q    <= '0;
      intv_q     <= '0;
      rbank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      iter_idx_q <= iter_idx_d;
      iters_q    <= iters_d;
      intv_q     <= intv_d;
      rbank_q    <= rbank_d;
    end
  end

  // Next-state and counter update; abort overrides everything outside IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    iter_idx_d = iter_idx_q;
    iters_d    = iters_q;
    intv_d     = intv_q;
    rbank_d    = rbank_q;
    take_next  = 1'b0;
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            iters_d    = iterations;
            intv_d     = exchange_interval;
            iter_idx_d = '0;
            phase_d    = '0;
            state_d    = StSeed;
          end
        end
        StSeed: state_d = (iters_q == '0) ? StDone : StRand;
        StRand: begin
          cnt_d   = DistLoad;
          state_d = StDist;
        end
        StDist: begin
          if (cnt_q == '0) state_d = StMetro;
          else             cnt_d   = cnt_q - 1'b1;
        end
        StMetro: begin
          cnt_d   = OrdLoad;
          state_d = StOrd;
        end
        StOrd: begin
          if (cnt_q == '0) begin
            rbank_d = ~rbank_q;
            // Phase counter stands in for (iter_idx+1) mod exchange_interval
            if (intv_q != '0 && phase_q == intv_q - 8'd1) begin
              phase_d = '0;
              state_d = StRepl;
            end else begin
              phase_d   = phase_q + 8'd1;
              take_next = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StRepl: state_d = StXchg;
        StXchg: take_next = 1'b1;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
      // NEXT: pseudo-state folded into the exit edge of ORD or XCHG
      if (take_next) begin
        iter_idx_d = iter_inc;
        state_d    = (iter_inc == iters_q) ? StDone : StRand;
      end
    end
  end

  // Output decode of the current state, registered below
  always_comb begin
    strobes_d = '0;
    unique case (state_q)
      StIdle:  strobes_d = 10'b00_0000_0000;
      StSeed:  strobes_d = 10'b10_1000_0000;
      StRand:  strobes_d = 10'b10_0100_0000;
      StDist:  strobes_d = (cnt_q == DistLoad) ? 10'b10_0010_0000 : 10'b10_0000_0000;
      StMetro: strobes_d = 10'b10_0001_0000;
      StOrd:   strobes_d = 10'b10_0000_1000;
      StRepl:  strobes_d = 10'b10_0000_0100;
      StXchg:  strobes_d = 10'b10_0000_0011;
      StDone:  strobes_d = 10'b11_0000_0000;
      default: strobes_d = '0;
    endcase
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) strobes_q <= '0;
    else       strobes_q <= strobes_d;
  end

  assign busy           = strobes_q[9];
  assign done           = strobes_q[8];
  assign random_init    = strobes_q[7];
  assign random_run     = strobes_q[6];
  assign distance_start = strobes_q[5];
  assign metropolis_run = strobes_q[4];
  assign exchange_valid = strobes_q[3];
  assign replica_run    = strobes_q[2];
  assign exchange_run   = strobes_q[1];
  assign shift_distance = strobes_q[0];
  assign iter_idx       = iter_idx_q;
  assign rbank          = rbank_q;
  assign opt_sel        = iter_idx_q[0];

endmodule
